piso_serializer: RTL and testbench

Parametrised parallel-in/serial-out shifter, the next generation of the UART TX serializer. It takes a DATA_WIDTH word over a valid/ready handshake and shifts it out one bit per ser_en cycle, LSB- or MSB-first. It provides a stall-tolerant bit counter, a single-cycle-accurate done flag and a busy flag for the TX FSM. It sits between the TX FIFO/ALU result path and the UART TX frame FSM (start/parity/stop muxing).

---
 rtl/serializer_pkg.sv | 24 ++
 rtl/piso_serializer.sv | 180 ++++++++++++++++++
 tb/tb_piso_serializer.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serializer_pkg.sv
// -----------------------------------------------------------------------------
// serializer_pkg
// Shared definitions for the PISO serializer used by the UART TX path.
//   state_t         : two-state FSM encoding (IDLE, SHIFT), 1 bit
//   cnt_width()     : bit-counter width for a given word width
//   DATA_WIDTH_MIN/ : legal range of the serializer word width
//   DATA_WIDTH_MAX
// -----------------------------------------------------------------------------
package serializer_pkg;

  localparam int DATA_WIDTH_MIN = 2;
  localparam int DATA_WIDTH_MAX = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Width of a counter that must hold 0..w-1.
  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
// Parallel-in / serial-out shifter feeding the UART TX frame FSM. A word is
// taken over a valid/ready handshake and shifted out one bit per ser_en edge,
// LSB- or MSB-first.
//
// Parameters:
//   DATA_WIDTH : word width, 2..32 (elaboration error otherwise)
//   LSB_FIRST  : 1 = bit 0 first, 0 = bit DATA_WIDTH-1 first
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active-low
//   p_data     in   parallel word
//   data_valid in   p_data valid
//   data_ready out  word accepted at the edge when data_valid && data_ready
//   ser_en     in   advance one bit at this edge
//   ser_data   out  current serial bit (0 when idle)
//   ser_done   out  current ser_data is the last bit of the word
//   ser_busy   out  word in flight
//
// Build option:
//   SERIALIZER_HOLD_EN : adds a one-entry hold buffer so a second word can be
//                        queued during SHIFT and follow with no idle cycle.
// -----------------------------------------------------------------------------
module piso_serializer
  import serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit LSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic                  ser_en,
  output logic                  ser_data,
  output logic                  ser_done,
  output logic                  ser_busy
);

  localparam int              CNT_W    = cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  if (DATA_WIDTH < DATA_WIDTH_MIN || DATA_WIDTH > DATA_WIDTH_MAX) begin : g_width_check
    $error("piso_serializer: DATA_WIDTH must be in 2..32");
  end

  state_t                  state_r, state_nxt_s;
  logic [DATA_WIDTH-1:0]   shift_r, shift_nxt_s, shifted_s;
  logic [CNT_W-1:0]        count_r, count_nxt_s;
  logic                    accept_s;
  logic                    last_s;

`ifdef SERIALIZER_HOLD_EN
  logic [DATA_WIDTH-1:0]   hold_data_r, hold_data_nxt_s;
  logic                    hold_full_r, hold_full_nxt_s;

  // Ready whenever the hold slot is free, in either state.
  assign data_ready = !hold_full_r;
`else
  // Without a hold slot, a new word is only taken while idle.
  assign data_ready = (state_r == IDLE);
`endif

  assign accept_s = data_valid && data_ready;
  assign last_s   = (count_r == CNT_LAST);

  // Outputs decoded straight from registers so the first bit appears the
  // cycle after accept and ser_done covers stalls on the last bit.
  assign ser_busy = (state_r == SHIFT);
  assign ser_done = (state_r == SHIFT) && last_s;
  assign ser_data = (state_r == SHIFT) ?
                    (LSB_FIRST ? shift_r[0] : shift_r[DATA_WIDTH-1]) : 1'b0;

  // Shift toward the output end with zero fill.
  always_comb begin
    if (LSB_FIRST) begin
      shifted_s = {1'b0, shift_r[DATA_WIDTH-1:1]};
    end else begin
      shifted_s = {shift_r[DATA_WIDTH-2:0], 1'b0};
    end
  end

  // Next-state, shift register, bit counter and hold-slot update.
  always_comb begin
    state_nxt_s = state_r;
    shift_nxt_s = shift_r;
    count_nxt_s = count_r;
`ifdef SERIALIZER_HOLD_EN
    hold_data_nxt_s = hold_data_r;
    hold_full_nxt_s = hold_full_r;
`endif
    case (state_r)
      IDLE: begin
        // ser_en has no effect while idle.
        if (accept_s) begin
          shift_nxt_s = p_data;
          count_nxt_s = '0;
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (ser_en && !last_s) begin
          shift_nxt_s = shifted_s;
          count_nxt_s = count_r + CNT_W'(1);
        end else if (ser_en) begin
`ifdef SERIALIZER_HOLD_EN
          // Word boundary: chain the held word, or bypass a word arriving
          // on this very edge, so the line never goes idle between words.
          if (hold_full_r) begin
            shift_nxt_s     = hold_data_r;
            hold_full_nxt_s = 1'b0;
            count_nxt_s     = '0;
          end else if (accept_s) begin
            shift_nxt_s = p_data;
            count_nxt_s = '0;
          end else begin
            shift_nxt_s = '0;
            count_nxt_s = '0;
            state_nxt_s = IDLE;
          end
`else
          shift_nxt_s = '0;
          count_nxt_s = '0;
          state_nxt_s = IDLE;
`endif
        end else begin
          // Stall: shift_reg and count hold their values.
          state_nxt_s = SHIFT;
        end
`ifdef SERIALIZER_HOLD_EN
        // An accept that is not consumed by the boundary bypass goes to the
        // hold slot; at a boundary with the slot full, data_ready is low.
        if (accept_s && !(ser_en && last_s)) begin
          hold_data_nxt_s = p_data;
          hold_full_nxt_s = 1'b1;
        end else begin
          hold_data_nxt_s = hold_data_nxt_s;
        end
`endif
      end
      default: begin
        state_nxt_s = IDLE;
        shift_nxt_s = '0;
        count_nxt_s = '0;
      end
    endcase
  end

  // State, shift register and counter flops; reset discards any word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      shift_r <= '0;
      count_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      shift_r <= shift_nxt_s;
      count_r <= count_nxt_s;
    end
  end

`ifdef SERIALIZER_HOLD_EN
  // Hold-slot flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_data_r <= '0;
      hold_full_r <= 1'b0;
    end else begin
      hold_data_r <= hold_data_nxt_s;
      hold_full_r <= hold_full_nxt_s;
    end
  end
`endif

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
// Bench for piso_serializer with two instances: 8-bit LSB-first and 12-bit
// MSB-first. Expected serial streams come from a word-level model: bit k of
// the stream is word bit k (LSB-first) or word bit DW-1-k (MSB-first), the
// bit index advances only on cycles with ser_en high, and ser_done is high
// whenever the index is DW-1.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]  pd8;
  logic        v8, en8;
  logic        rdy8, sd8, dn8, bz8;
  logic [11:0] pd12;
  logic        v12, en12;
  logic        rdy12, sd12, dn12, bz12;

  piso_serializer #(.DATA_WIDTH(8), .LSB_FIRST(1'b1)) u8 (
    .clk(clk), .rst(rst), .p_data(pd8), .data_valid(v8), .data_ready(rdy8),
    .ser_en(en8), .ser_data(sd8), .ser_done(dn8), .ser_busy(bz8)
  );

  piso_serializer #(.DATA_WIDTH(12), .LSB_FIRST(1'b0)) u12 (
    .clk(clk), .rst(rst), .p_data(pd12), .data_valid(v12), .data_ready(rdy12),
    .ser_en(en12), .ser_data(sd12), .ser_done(dn12), .ser_busy(bz12)
  );

  int checks = 0;
  int failures = 0;

  // Captured per-cycle DUT outputs
  logic cap_d [64];
  logic cap_dn[64];
  logic cap_bz[64];
  int   cap_n;
  logic cap_rdy_end, cap_bz_end, cap_rdy_pulse;

  // Model outputs
  logic exp_d [64];
  logic exp_dn[64];
  int   exp_n;

  // Word-level reference: which word bit is on the line each cycle.
  task automatic model_word(input int dw, input bit lsb, input logic [31:0] w,
                            input int stall_at, input int stall_len);
    int idx = 0;
    bit en;
    exp_n = dw + stall_len;
    for (int c = 0; c < exp_n; c++) begin
      exp_d[c]  = lsb ? w[idx] : w[dw-1-idx];
      exp_dn[c] = (idx == dw - 1);
      en = !(c >= stall_at && c < stall_at + stall_len);
      if (en && idx < dw - 1) idx++;
    end
  endtask

  // Drive one word into instance sel (0: 8-bit, 1: 12-bit) and record outputs.
  task automatic run_word(input int sel, input logic [31:0] w, input int stall_at,
                          input int stall_len, input int pulse_at);
    int dw = (sel == 0) ? 8 : 12;
    bit en;
    if (sel == 0) begin pd8 = w[7:0]; v8 = 1'b1; end
    else begin pd12 = w[11:0]; v12 = 1'b1; end
    @(posedge clk); #1;
    v8 = 1'b0; v12 = 1'b0;
    pd8 = 8'($urandom); pd12 = 12'($urandom);
    cap_n = dw + stall_len;
    for (int c = 0; c < cap_n; c++) begin
      cap_d[c]  = (sel == 0) ? sd8 : sd12;
      cap_dn[c] = (sel == 0) ? dn8 : dn12;
      cap_bz[c] = (sel == 0) ? bz8 : bz12;
      if (c == pulse_at) begin
        pd8 = 8'h55; v8 = 1'b1; cap_rdy_pulse = rdy8;
      end
      en = !(c >= stall_at && c < stall_at + stall_len);
      if (sel == 0) en8 = en; else en12 = en;
      @(posedge clk); #1;
      v8 = 1'b0;
    end
    en8 = 1'b0; en12 = 1'b0;
    cap_rdy_end = (sel == 0) ? rdy8 : rdy12;
    cap_bz_end  = (sel == 0) ? bz8 : bz12;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    checks++;
    if ({rdy8, sd8, dn8, bz8} !== 4'b1000) begin
      failures++;
      $display("FAIL reset8: rdy/data/done/busy=%b%b%b%b want 1000", rdy8, sd8, dn8, bz8);
    end
    checks++;
    if ({rdy12, sd12, dn12, bz12} !== 4'b1000) begin
      failures++;
      $display("FAIL reset12: rdy/data/done/busy=%b%b%b%b want 1000", rdy12, sd12, dn12, bz12);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({rdy8, bz8, sd8} !== 3'b100) begin
      failures++;
      $display("FAIL after_release: rdy/busy/data=%b%b%b want 100", rdy8, bz8, sd8);
    end
  endtask

  task automatic test_lsb_first();
    run_word(0, 32'hA5, 99, 0, -1);
    model_word(8, 1'b1, 32'hA5, 99, 0);
    for (int c = 0; c < cap_n; c++) begin
      checks++;
      if (cap_d[c] !== exp_d[c] || cap_dn[c] !== exp_dn[c] || cap_bz[c] !== 1'b1) begin
        failures++;
        $display("FAIL lsb_a5 cyc%0d: data=%b done=%b busy=%b want %b %b 1",
                 c, cap_d[c], cap_dn[c], cap_bz[c], exp_d[c], exp_dn[c]);
      end
    end
    checks++;
    if (cap_rdy_end !== 1'b1 || cap_bz_end !== 1'b0) begin
      failures++;
      $display("FAIL lsb_a5_end: rdy=%b busy=%b want 1 0", cap_rdy_end, cap_bz_end);
    end
  endtask

  task automatic test_msb_first();
    // Second word stalls on its last bit: ser_done must stay up, no wrap.
    int sa [2] = '{99, 11};
    int sl [2] = '{0, 2};
    logic [31:0] ws [2] = '{32'h8C3, 32'h5A6};
    for (int k = 0; k < 2; k++) begin
      run_word(1, ws[k], sa[k], sl[k], -1);
      model_word(12, 1'b0, ws[k], sa[k], sl[k]);
      for (int c = 0; c < cap_n; c++) begin
        checks++;
        if (cap_d[c] !== exp_d[c] || cap_dn[c] !== exp_dn[c] || cap_bz[c] !== 1'b1) begin
          failures++;
          $display("FAIL msb12 w%0d cyc%0d: data=%b done=%b busy=%b want %b %b 1",
                   k, c, cap_d[c], cap_dn[c], cap_bz[c], exp_d[c], exp_dn[c]);
        end
      end
      checks++;
      if (cap_rdy_end !== 1'b1 || cap_bz_end !== 1'b0) begin
        failures++;
        $display("FAIL msb12_end w%0d: rdy=%b busy=%b want 1 0", k, cap_rdy_end, cap_bz_end);
      end
    end
  endtask

  task automatic test_stall();
    run_word(0, 32'h0F, 2, 3, -1);
    model_word(8, 1'b1, 32'h0F, 2, 3);
    for (int c = 0; c < cap_n; c++) begin
      checks++;
      if (cap_d[c] !== exp_d[c] || cap_dn[c] !== exp_dn[c] || cap_bz[c] !== 1'b1) begin
        failures++;
        $display("FAIL stall_0f cyc%0d: data=%b done=%b busy=%b want %b %b 1",
                 c, cap_d[c], cap_dn[c], cap_bz[c], exp_d[c], exp_dn[c]);
      end
    end
  endtask

`ifndef SERIALIZER_HOLD_EN
  task automatic test_ignore_valid();
    run_word(0, 32'h3C, 99, 0, 3);
    model_word(8, 1'b1, 32'h3C, 99, 0);
    checks++;
    if (cap_rdy_pulse !== 1'b0) begin
      failures++;
      $display("FAIL ignore_ready: data_ready=%b want 0", cap_rdy_pulse);
    end
    for (int c = 0; c < cap_n; c++) begin
      checks++;
      if (cap_d[c] !== exp_d[c] || cap_dn[c] !== exp_dn[c]) begin
        failures++;
        $display("FAIL ignore_3c cyc%0d: data=%b done=%b want %b %b",
                 c, cap_d[c], cap_dn[c], exp_d[c], exp_dn[c]);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (bz8 !== 1'b0 || rdy8 !== 1'b1) begin
      failures++;
      $display("FAIL ignore_end: busy=%b rdy=%b want 0 1", bz8, rdy8);
    end
  endtask
`else
  task automatic test_hold();
    logic [23:0] stream = 24'h332211;
    pd8 = 8'h11; v8 = 1'b1;
    @(posedge clk); #1;
    en8 = 1'b1;
    for (int c = 0; c < 24; c++) begin
      checks++;
      if (sd8 !== stream[c] || dn8 !== (c % 8 == 7) || bz8 !== 1'b1) begin
        failures++;
        $display("FAIL hold cyc%0d: data=%b done=%b busy=%b want %b %b 1",
                 c, sd8, dn8, bz8, stream[c], (c % 8 == 7));
      end
      v8 = 1'b0;
      if (c == 0 || c == 15) begin
        pd8 = (c == 0) ? 8'h22 : 8'h33; v8 = 1'b1;
        checks++;
        if (rdy8 !== 1'b1) begin
          failures++;
          $display("FAIL hold_ready cyc%0d: data_ready=%b want 1", c, rdy8);
        end
      end else if (c >= 2 && c <= 4) begin
        pd8 = 8'h33; v8 = 1'b1;
        checks++;
        if (rdy8 !== 1'b0) begin
          failures++;
          $display("FAIL hold_full cyc%0d: data_ready=%b want 0", c, rdy8);
        end
      end
      @(posedge clk); #1;
    end
    v8 = 1'b0; en8 = 1'b0;
    checks++;
    if (bz8 !== 1'b0 || rdy8 !== 1'b1) begin
      failures++;
      $display("FAIL hold_end: busy=%b rdy=%b want 0 1", bz8, rdy8);
    end
  endtask
`endif

  task automatic test_reset_mid_word();
    pd8 = 8'hFF; v8 = 1'b1;
    @(posedge clk); #1;
    v8 = 1'b0; en8 = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    checks++;
    if ({rdy8, sd8, dn8, bz8} !== 4'b1000) begin
      failures++;
      $display("FAIL rst_mid: rdy/data/done/busy=%b%b%b%b want 1000", rdy8, sd8, dn8, bz8);
    end
    en8 = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bz8 !== 1'b0 || sd8 !== 1'b0) begin
      failures++;
      $display("FAIL rst_release: busy=%b data=%b want 0 0", bz8, sd8);
    end
    run_word(0, 32'h01, 99, 0, -1);
    model_word(8, 1'b1, 32'h01, 99, 0);
    for (int c = 0; c < cap_n; c++) begin
      checks++;
      if (cap_d[c] !== exp_d[c] || cap_dn[c] !== exp_dn[c] || cap_bz[c] !== 1'b1) begin
        failures++;
        $display("FAIL rst_01 cyc%0d: data=%b done=%b busy=%b want %b %b 1",
                 c, cap_d[c], cap_dn[c], cap_bz[c], exp_d[c], exp_dn[c]);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 12; k++) begin
      int sel = k % 2;
      int dw = (sel == 0) ? 8 : 12;
      logic [31:0] w = $urandom;
      int sa = $urandom_range(dw - 1, 0);
      int sl = $urandom_range(4, 0);
      run_word(sel, w, sa, sl, -1);
      model_word(dw, (sel == 0), w, sa, sl);
      for (int c = 0; c < cap_n; c++) begin
        checks++;
        if (cap_d[c] !== exp_d[c] || cap_dn[c] !== exp_dn[c] || cap_bz[c] !== 1'b1) begin
          failures++;
          $display("FAIL rand%0d cyc%0d w=%h: data=%b done=%b busy=%b want %b %b 1",
                   k, c, w, cap_d[c], cap_dn[c], cap_bz[c], exp_d[c], exp_dn[c]);
        end
      end
      checks++;
      if (cap_rdy_end !== 1'b1 || cap_bz_end !== 1'b0) begin
        failures++;
        $display("FAIL rand%0d_end: rdy=%b busy=%b want 1 0", k, cap_rdy_end, cap_bz_end);
      end
    end
  endtask

  initial begin
    pd8 = 8'h00; v8 = 1'b0; en8 = 1'b0;
    pd12 = 12'h000; v12 = 1'b0; en12 = 1'b0;
    cap_rdy_pulse = 1'b0;
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_stall();
`ifndef SERIALIZER_HOLD_EN
    test_ignore_valid();
`else
    test_hold();
`endif
    test_reset_mid_word();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
